// File: rtl/syncnt_timer_if.sv
// Register/count interface of the programmable timer: control strobes,
// load and write data, and the count/event outputs.
interface syncnt_timer_if #(
  parameter int unsigned W = 9
);
  logic         EN;
  logic         CLR;
  logic         LDL;
  logic [W-1:0] D;
  logic         START;
  logic         MODE;
  logic         WR_TC;
  logic         WR_CMP;
  logic [W-1:0] DIN;
  logic         ACK;
  logic [W-1:0] Q;
  logic [W-1:0] QB;
  logic         CO;
  logic         TC_P;
  logic         CMP_P;
  logic         DONE;
  logic         STAT;

  // Controller side: drives strobes and data, observes count and events
  modport master (
    output EN, CLR, LDL, D, START, MODE, WR_TC, WR_CMP, DIN, ACK,
    input  Q, QB, CO, TC_P, CMP_P, DONE, STAT
  );

  // Timer side
  modport slave (
    input  EN, CLR, LDL, D, START, MODE, WR_TC, WR_CMP, DIN, ACK,
    output Q, QB, CO, TC_P, CMP_P, DONE, STAT
  );
endinterface

// File: rtl/syncnt_timer.sv
// W-bit programmable timer: load/clear/start/count with terminal-count
// reload or one-shot hold, compare event, and a sticky terminal-count flag.
module syncnt_timer #(
  parameter int unsigned W = 9
) (
  input logic            CLK,
  input logic            RESETL,
  syncnt_timer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [W-1:0] ONE = W'(1);

  state_t       state, state_next;
  logic [W-1:0] q, q_next;
  logic [W-1:0] tc_reg, cmp_reg;
  logic         tc_p, tc_p_next;
  logic         cmp_p, cmp_p_next;
  logic         stat, stat_next;
  logic         tc_event;

  // Next-state logic: load > clear > start > count; pulses default low
  always_comb begin
    state_next = state;
    q_next     = q;
    tc_p_next  = 1'b0;
    cmp_p_next = 1'b0;
    tc_event   = 1'b0;
    if (!bus.LDL) begin
      q_next = bus.D;
    end else if (bus.CLR) begin
      q_next     = '0;
      state_next = IDLE;
    end else if (bus.START) begin
      q_next     = '0;
      state_next = RUN;
    end else if (state == RUN && bus.EN) begin
      cmp_p_next = (q == cmp_reg);
      if (q == tc_reg) begin
        tc_p_next = 1'b1;
        tc_event  = 1'b1;
        if (bus.MODE) begin
          state_next = HOLD;
        end else begin
          q_next = '0;
        end
      end else begin
        q_next = q + ONE;
      end
    end
    // A terminal-count event wins over a coincident acknowledge
    stat_next = tc_event | (stat & ~bus.ACK);
  end

  // Count, state, pulse and status registers
  always_ff @(posedge CLK or negedge RESETL) begin
    if (!RESETL) begin
      state <= IDLE;
      q     <= '0;
      tc_p  <= 1'b0;
      cmp_p <= 1'b0;
      stat  <= 1'b0;
    end else begin
      state <= state_next;
      q     <= q_next;
      tc_p  <= tc_p_next;
      cmp_p <= cmp_p_next;
      stat  <= stat_next;
    end
  end

  // Period and compare registers; the compare on a write edge sees the old value
  always_ff @(posedge CLK or negedge RESETL) begin
    if (!RESETL) begin
      tc_reg  <= '1;
      cmp_reg <= '1;
    end else begin
      if (bus.WR_TC)  tc_reg  <= bus.DIN;
      if (bus.WR_CMP) cmp_reg <= bus.DIN;
    end
  end

  assign bus.Q     = q;
  assign bus.QB    = ~q;
  assign bus.CO    = bus.EN & (state == RUN) & (q == '1);
  assign bus.TC_P  = tc_p;
  assign bus.CMP_P = cmp_p;
  assign bus.DONE  = (state == HOLD);
  assign bus.STAT  = stat;

endmodule

// File: tb/tb_syncnt_timer.sv
// Bench for syncnt_timer: directed scenarios followed by random stimulus,
// all outputs compared against a behavioural model after every edge.
module tb_syncnt_timer;

  localparam int unsigned W    = 9;
  localparam int          MODN = 512;

  logic CLK;
  logic RESETL;

  syncnt_timer_if #(.W(W)) bus ();

  syncnt_timer #(.W(W)) dut (
    .CLK    (CLK),
    .RESETL (RESETL),
    .bus    (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  // Model state
  int m_q;
  int m_tc;
  int m_cmp;
  bit m_run;
  bit m_hold;
  bit m_stat;
  bit m_tcp;
  bit m_cmpp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q = 0; m_tc = MODN - 1; m_cmp = MODN - 1;
    m_run = 0; m_hold = 0; m_stat = 0; m_tcp = 0; m_cmpp = 0;
  endtask

  // One clock edge of the timer, evaluated from the rule list using the inputs present now
  task automatic model_edge();
    bit hit;
    hit = 0; m_tcp = 0; m_cmpp = 0;
    if (bus.LDL === 1'b0) begin
      m_q = int'(bus.D);
    end else if (bus.CLR) begin
      m_q = 0; m_run = 0; m_hold = 0;
    end else if (bus.START) begin
      m_q = 0; m_run = 1; m_hold = 0;
    end else if (m_run && bus.EN) begin
      m_cmpp = (m_q == m_cmp);
      if (m_q == m_tc) begin
        hit = 1; m_tcp = 1;
        if (bus.MODE) begin m_run = 0; m_hold = 1; end
        else m_q = 0;
      end else begin
        m_q = (m_q + 1) % MODN;
      end
    end
    if (hit) m_stat = 1;
    else if (bus.ACK) m_stat = 0;
    if (bus.WR_TC)  m_tc  = int'(bus.DIN);
    if (bus.WR_CMP) m_cmp = int'(bus.DIN);
  endtask

  task automatic check_all(input string tag);
    bit co;
    co = bus.EN && m_run && (m_q == MODN - 1);
    chk({tag, "_q"},    32'(bus.Q),     32'(m_q));
    chk({tag, "_qb"},   32'(bus.QB),    32'((MODN - 1) - m_q));
    chk({tag, "_co"},   32'(bus.CO),    32'(co));
    chk({tag, "_tcp"},  32'(bus.TC_P),  32'(m_tcp));
    chk({tag, "_cmpp"}, 32'(bus.CMP_P), 32'(m_cmpp));
    chk({tag, "_done"}, 32'(bus.DONE),  32'(m_hold));
    chk({tag, "_stat"}, 32'(bus.STAT),  32'(m_stat));
  endtask

  task automatic idle_inputs();
    bus.EN = 0; bus.CLR = 0; bus.LDL = 1; bus.D = '0; bus.START = 0;
    bus.MODE = 0; bus.WR_TC = 0; bus.WR_CMP = 0; bus.DIN = '0; bus.ACK = 0;
  endtask

  task automatic tick(input string tag);
    model_edge();
    @(posedge CLK);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    RESETL = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    @(posedge CLK);
    #1;
    RESETL = 1'b1;
  endtask

  initial begin
    RESETL = 1'b1;
    idle_inputs();
    #2;
    do_reset("rst");

    // Free-run with TC=5: Q 0..5,0..; TC_P the cycle after Q=5
    bus.WR_TC = 1; bus.DIN = 9'd5; tick("t1_wr");
    idle_inputs(); bus.START = 1; tick("t1_start");
    idle_inputs(); bus.EN = 1;
    for (int i = 0; i < 14; i++) begin
      tick("t1_run");
      if (m_q == 0 && i == 5) chk("t1_tcp_wrap", 32'(bus.TC_P), 32'd1);
    end
    chk("t1_stat", 32'(bus.STAT), 32'd1);
    bus.ACK = 1; tick("t1_ack");
    chk("t1_stat_clr", 32'(bus.STAT), 32'd0);

    // One-shot with TC=3: counts to 3, holds, DONE; restart clears DONE
    idle_inputs(); bus.WR_TC = 1; bus.DIN = 9'd3; bus.MODE = 1; bus.START = 1; tick("t2_start");
    idle_inputs(); bus.MODE = 1; bus.EN = 1;
    for (int i = 0; i < 7; i++) tick("t2_run");
    chk("t2_hold_q", 32'(bus.Q), 32'd3);
    chk("t2_done", 32'(bus.DONE), 32'd1);
    bus.START = 1; tick("t2_restart");
    chk("t2_done_clr", 32'(bus.DONE), 32'd0);

    // TC=511 from Q=510: CO at 511, then wrap with TC_P
    do_reset("t3_rst");
    bus.START = 1; tick("t3_start");
    idle_inputs(); bus.LDL = 0; bus.D = 9'd510; tick("t3_load");
    idle_inputs(); bus.EN = 1; tick("t3_511");
    chk("t3_co", 32'(bus.CO), 32'd1);
    tick("t3_wrap");
    chk("t3_tcp", 32'(bus.TC_P), 32'd1);

    // Load beats clear and start on the same edge; then clear alone
    idle_inputs(); bus.EN = 1; bus.LDL = 0; bus.D = 9'd7; bus.CLR = 1; bus.START = 1; tick("t4_all");
    chk("t4_q7", 32'(bus.Q), 32'd7);
    idle_inputs(); bus.CLR = 1; tick("t4_clr");
    idle_inputs(); bus.EN = 1; tick("t4_idle");

    // Compare at 2, TC=4, free-run; ACK coincident with TC event
    idle_inputs(); bus.WR_CMP = 1; bus.DIN = 9'd2; tick("t5_wrc");
    idle_inputs(); bus.WR_TC = 1; bus.DIN = 9'd4; bus.START = 1; tick("t5_start");
    idle_inputs(); bus.EN = 1;
    for (int i = 0; i < 12; i++) begin
      bus.ACK = (m_q == 4);
      tick("t5_run");
      if (bus.ACK) chk("t5_stat_ack", 32'(bus.STAT), 32'd1);
    end

    // TC written below current Q: runs on through the wrap
    idle_inputs(); bus.EN = 1; bus.WR_TC = 1; bus.DIN = 9'd2; tick("t7_wr");
    idle_inputs(); bus.EN = 1;
    for (int i = 0; i < 8; i++) tick("t7_run");
    idle_inputs(); bus.LDL = 0; bus.D = 9'd300; tick("t7_ld");
    idle_inputs(); bus.EN = 1;
    for (int i = 0; i < 220; i++) tick("t7_long");

    // Async reset mid-run with Q=3
    idle_inputs(); bus.WR_TC = 1; bus.DIN = 9'd20; bus.START = 1; tick("t6_start");
    idle_inputs(); bus.EN = 1;
    for (int i = 0; i < 3; i++) tick("t6_run");
    chk("t6_q3", 32'(bus.Q), 32'd3);
    #2;
    RESETL = 1'b0;
    #1;
    model_reset();
    check_all("t6_async");
    #1;
    RESETL = 1'b1;

    // Random stimulus
    for (int i = 0; i < 1500; i++) begin
      bus.EN     = ($urandom_range(0, 3) != 0);
      bus.LDL    = ($urandom_range(0, 15) != 0);
      bus.D      = 9'($urandom_range(0, MODN - 1));
      bus.CLR    = ($urandom_range(0, 31) == 0);
      bus.START  = ($urandom_range(0, 15) == 0);
      bus.MODE   = ($urandom_range(0, 3) == 0);
      bus.WR_TC  = ($urandom_range(0, 15) == 0);
      bus.WR_CMP = ($urandom_range(0, 15) == 0);
      bus.DIN    = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(0, MODN - 1))
                                               : 9'($urandom_range(0, 12));
      bus.ACK    = ($urandom_range(0, 7) == 0);
      tick("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
